// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared depth helper, legal parameter ranges and count type for sync_fifo_fwft.
//   SYNC_FIFO_CNT_T(ab) expands to the (ab+1)-bit occupancy/pointer type.
`ifndef SYNC_FIFO_CNT_T
`define SYNC_FIFO_CNT_T(ab) logic [(ab):0]
`endif

package sync_fifo_pkg;

    localparam int ADR_BIT_MIN = 1;
    localparam int ADR_BIT_MAX = 10;

    function automatic int fifo_depth(input int adr_bit);
        return 1 << adr_bit;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: ADR_BIT+1-bit wrap pointer; the MSB toggles on every wrap.
//   clk, rst : clock, async active-high reset
//   inc      : advance the pointer by one this cycle
//   ptr      : current pointer value
module sync_fifo_ptr #(
    parameter int ADR_BIT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ADR_BIT:0] ptr
);

    typedef `SYNC_FIFO_CNT_T(ADR_BIT) ptr_t;

    ptr_t ptr_q, ptr_d;

    always_comb ptr_d = inc ? ptr_q + ptr_t'(1) : ptr_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO with valid/ready on both sides.
//   write side : wr_vld, wr_rdy, wr_dat
//   read side  : rd_vld, rd_rdy, rd_dat (head shown combinationally, 0 when empty)
//   status     : fifo_count, almost_full (>= AFULL_TH), almost_empty (<= AEMPTY_TH)
//   errors     : ovf, udf sticky, cleared by err_clr; only built with SYNC_FIFO_ERR_EN,
//                otherwise tied to 0 and err_clr is ignored
module sync_fifo_fwft import sync_fifo_pkg::*; #(
    parameter int DAT_BIT   = 32,
    parameter int ADR_BIT   = 6,
    parameter int AFULL_TH  = fifo_depth(ADR_BIT) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_vld,
    output logic               wr_rdy,
    input  logic [DAT_BIT-1:0] wr_dat,
    output logic               rd_vld,
    input  logic               rd_rdy,
    output logic [DAT_BIT-1:0] rd_dat,
    output logic [ADR_BIT:0]   fifo_count,
    output logic               almost_full,
    output logic               almost_empty,
    input  logic               err_clr,
    output logic               ovf,
    output logic               udf
);

    localparam int DEPTH = fifo_depth(ADR_BIT);

    typedef `SYNC_FIFO_CNT_T(ADR_BIT) cnt_t;

    if (ADR_BIT < ADR_BIT_MIN || ADR_BIT > ADR_BIT_MAX) begin : g_bad_adr
        $error("sync_fifo_fwft: ADR_BIT out of range");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_fwft: AFULL_TH out of range");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_fwft: AEMPTY_TH out of range");
    end

    localparam cnt_t AF_TH = cnt_t'(AFULL_TH);
    localparam cnt_t AE_TH = cnt_t'(AEMPTY_TH);

    logic [DAT_BIT-1:0] mem_q [DEPTH];
    cnt_t               wr_ptr, rd_ptr;
    cnt_t               count_q, count_d;
    logic               full, empty, push, pop;

    // Full when the wrap bits differ and the slot indices match.
    assign full   = wr_ptr == {~rd_ptr[ADR_BIT], rd_ptr[ADR_BIT-1:0]};
    assign empty  = wr_ptr == rd_ptr;
    assign wr_rdy = !full && !rst;
    assign rd_vld = !empty;
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;
    assign rd_dat = rd_vld ? mem_q[rd_ptr[ADR_BIT-1:0]] : '0;

    sync_fifo_ptr #(.ADR_BIT(ADR_BIT)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wr_ptr)
    );

    sync_fifo_ptr #(.ADR_BIT(ADR_BIT)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr[ADR_BIT-1:0]] <= wr_dat;

    always_comb count_d = count_q + cnt_t'(push) - cnt_t'(pop);

    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else     count_q <= count_d;

    assign fifo_count   = count_q;
    assign almost_full  = count_q >= AF_TH;
    assign almost_empty = count_q <= AE_TH;

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        ovf_d = (wr_vld && !wr_rdy && !rst) || (ovf_q && !err_clr);
        udf_d = (rd_rdy && !rd_vld) || (udf_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    logic err_clr_unused;

    assign err_clr_unused = err_clr;
    assign ovf            = 1'b0;
    assign udf            = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed and random stimulus against a queue-based reference model.
module tb_sync_fifo_fwft;

    localparam int DW    = 32;
    localparam int AB    = 2;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int AET   = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_vld = 1'b0;
    logic          rd_rdy = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] wr_dat = '0;
    logic          wr_rdy, rd_vld, almost_full, almost_empty, ovf, udf;
    logic [DW-1:0] rd_dat;
    logic [AB:0]   fifo_count;

    sync_fifo_fwft #(
        .DAT_BIT   (DW),
        .ADR_BIT   (AB),
        .AFULL_TH  (AFT),
        .AEMPTY_TH (AET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_vld       (wr_vld),
        .wr_rdy       (wr_rdy),
        .wr_dat       (wr_dat),
        .rd_vld       (rd_vld),
        .rd_rdy       (rd_rdy),
        .rd_dat       (rd_dat),
        .fifo_count   (fifo_count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err_clr      (err_clr),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mq[$];
    logic          ovf_m = 1'b0;
    logic          udf_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int n;
        n = mq.size();
        chk({ph, ".count"},  32'(fifo_count),   32'(n));
        chk({ph, ".wr_rdy"}, 32'(wr_rdy),       32'(n < DEPTH));
        chk({ph, ".rd_vld"}, 32'(rd_vld),       32'(n > 0));
        chk({ph, ".rd_dat"}, rd_dat,            n > 0 ? mq[0] : 32'h0);
        chk({ph, ".afull"},  32'(almost_full),  32'(n >= AFT));
        chk({ph, ".aempty"}, 32'(almost_empty), 32'(n <= AET));
        chk({ph, ".ovf"},    32'(ovf),          32'(ovf_m));
        chk({ph, ".udf"},    32'(udf),          32'(udf_m));
    endtask

    task automatic rst_checks(input string ph);
        chk({ph, ".count"},  32'(fifo_count),   32'h0);
        chk({ph, ".wr_rdy"}, 32'(wr_rdy),       32'h0);
        chk({ph, ".rd_vld"}, 32'(rd_vld),       32'h0);
        chk({ph, ".rd_dat"}, rd_dat,            32'h0);
        chk({ph, ".afull"},  32'(almost_full),  32'h0);
        chk({ph, ".aempty"}, 32'(almost_empty), 32'h1);
        chk({ph, ".ovf"},    32'(ovf),          32'h0);
        chk({ph, ".udf"},    32'(udf),          32'h0);
    endtask

    // One clock cycle: drive, check pre-edge outputs against the model, then advance the model.
    task automatic step(input string ph, input logic wv, input logic [DW-1:0] wd,
                        input logic rr, input logic ec);
        bit can_push, can_pop;
        @(negedge clk);
        wr_vld  = wv;
        wr_dat  = wd;
        rd_rdy  = rr;
        err_clr = ec;
        #1 check_all(ph);
        can_push = wv && mq.size() < DEPTH;
        can_pop  = rr && mq.size() > 0;
`ifdef SYNC_FIFO_ERR_EN
        ovf_m = (wv && mq.size() == DEPTH) || (ovf_m && !ec);
        udf_m = (rr && mq.size() == 0) || (udf_m && !ec);
`endif
        if (can_pop) void'(mq.pop_front());
        if (can_push) mq.push_back(wd);
        @(posedge clk);
    endtask

    task automatic apply_reset(input string ph);
        @(negedge clk);
        wr_vld  = 1'b0;
        rd_rdy  = 1'b0;
        err_clr = 1'b0;
        rst     = 1'b1;
        #1 rst_checks(ph);
        mq.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2 rst_checks("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) step("load", 1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        apply_reset("midrst");
        step("post_rst", 1'b0, 32'h0, 1'b0, 1'b0);

        step("fwft_push", 1'b1, 32'h5A, 1'b0, 1'b0);
        step("fwft_see", 1'b0, 32'h0, 1'b1, 1'b0);
        step("fwft_done", 1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        step("fill_ovf", 1'b1, 32'hA4, 1'b0, 1'b0);
        #1 chk("fill.count4", 32'(fifo_count), 32'h4);
        step("full_pop", 1'b1, 32'hB0, 1'b1, 1'b0);
        step("full_repush", 1'b1, 32'hB0, 1'b0, 1'b0);
        step("full_chk", 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 32'h0, 1'b1, 1'b0);
        step("drained", 1'b0, 32'h0, 1'b0, 1'b0);

        step("udf_set", 1'b0, 32'h0, 1'b1, 1'b0);
        step("udf_setclr", 1'b0, 32'h0, 1'b1, 1'b1);
        step("udf_clr", 1'b0, 32'h0, 1'b0, 1'b1);
        step("udf_after", 1'b0, 32'h0, 1'b0, 1'b0);

        step("pp_pre", 1'b1, 32'hD0, 1'b0, 1'b0);
        step("pp_pre", 1'b1, 32'hD1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("pushpop", 1'b1, 32'hE0 + 32'(i), 1'b1, 1'b0);
        #1 chk("pushpop.count2", 32'(fifo_count), 32'h2);

        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));

        apply_reset("endrst");
        step("final", 1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
